sfp_accum: RTL and testbench
============================

# sfp_accum

Output-side accumulation stage placed directly downstream of the MAC column. It accepts one signed `psum_bw` partial sum per cycle from the column over a configurable number of passes. It accumulates these sums element-wise into a register bank of `depth` entries using signed saturating addition. After the last pass it drains the bank through a valid/ready port, with optional ReLU applied to each value.

## Interface
- `psum_bw`, 16: width of incoming partial sums and of stored and output values (signed).
- `depth`, 16: number of output locations per pass. Must be a power of two, ≥2.
- `pass_bw`, 4: width of the pass-count configuration.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a job. Accepted only in IDLE.
- `num_pass`  in  pass_bw  number of accumulation passes. Sampled at accepted `start`; 0 is treated as 1.
- `relu_en`  in  1  enables ReLU on drain. Sampled at accepted `start`.
- `in_valid`  in  1  MAC psum valid.
- `in_psum`  in  psum_bw  signed psum from the MAC output.
- `in_ready`  out  1  stage can accept a psum this cycle.
- `out_valid`  out  1  drained value is valid.
- `out_data`  out  psum_bw  drained value (signed, post-ReLU).
- `out_ready`  in  1  consumer accepts `out_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final drain handshake.

## Operation
- States: IDLE → ACC → DRAIN → IDLE.
- IDLE:
  - `start` latches `num_pass` (0 becomes 1) and `relu_en`, clears the address counter `addr` and the pass counter `pass`, and moves to ACC.
  - `in_valid` is ignored.
- ACC:
  - `in_ready`=1. Each beat (`in_valid`&`in_ready`) acts on `mem[addr]`:
    - pass 0: writes `in_psum` (overwrite, no add).
    - pass >0: writes sat(`mem[addr]` + `in_psum`).
  - `addr` increments by 1 per beat and wraps from depth-1 to 0. On wrap, `pass` increments.
  - On the wrap in the final pass (`pass`==num_pass-1), go to DRAIN with `addr`=0.
- Saturation:
  - Compute the sum at psum_bw+1 bits.
  - Clamp to [−2^(psum_bw−1), 2^(psum_bw−1)−1], i.e. 32767 / −32768 at the default width.
- DRAIN:
  - `out_valid`=1 and `in_ready`=0.
  - `out_data` = (relu_en && mem[addr]<0) ? 0 : mem[addr].
  - Each handshake (`out_valid`&`out_ready`) increments `addr`.
  - The handshake at addr=depth-1 returns the block to IDLE and pulses `done` for the following cycle.
- `start` outside IDLE is ignored, and the configuration is not re-sampled.
- `mem` is not cleared between jobs. The pass-0 overwrite makes stale contents irrelevant.

## Timing
- Reset (`reset_n`=0, asynchronous, taking effect mid-job as well):
  - State=IDLE; `addr`, `pass` and all `mem` entries = 0.
  - Outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
  - Any partial job is discarded. Release of reset is synchronous to `clk`.
- `in_ready` and `out_valid` are Moore outputs, decoded from state only. They have no combinational path from `in_valid` or `out_ready`.
- `start` accepted at edge T → `busy`=1 and `in_ready`=1 from T+1.
- One psum is accepted per cycle with no bubbles. A beat at edge T is visible in `mem` at T+1.
- Last ACC beat at edge T → `out_valid`=1 from T+1; the first drain value is mem[0].
- `out_data` is stable while `out_valid`&!`out_ready`. The address advances only on a handshake.
- Last drain handshake at edge T → `done`=1 and `busy`=0 during T+1..T+2. A new `start` can be accepted at T+1.
- Minimum job length with no stalls: 1 + num_pass·depth + depth cycles.

## Test plan
- Reset mid-ACC:
  - Stimulus: `num_pass`=2, feed 5 beats, pulse `reset_n` low for 1 cycle.
  - Required: `busy`=0, `in_ready`=0, `out_valid`=0 immediately while `reset_n` is low.
  - Then run a fresh job with `num_pass`=1 and `in_psum`=addr. Required drain: 0,1,…,15, then `done` pulse.
- Three-pass accumulation:
  - Stimulus: `num_pass`=3, `relu_en`=0, `in_psum`=addr+1 on every pass, random `in_valid` gaps.
  - Required drain: 3,6,…,48 in address order. `in_ready` stays 1 throughout ACC.
- Saturation both ways:
  - Stimulus: `num_pass`=2. Pass 0: entry0=30000, entry1=−30000. Pass 1: entry0=+5000, entry1=−5000.
  - Required drain: entry0=32767, entry1=−32768.
- ReLU:
  - Stimulus: `relu_en`=1, `num_pass`=1, `in_psum` alternating −7 / +7.
  - Required drain: 0,7,0,7,….
  - Same job with `relu_en`=0 → −7,7,….
- Backpressure on drain:
  - Stimulus: hold `out_ready`=0 for 4 cycles at entry 5, and toggle it randomly elsewhere.
  - Required: `out_data` constant during the stall, no entry skipped or duplicated, `done` exactly once.
- Illegal-input checks:
  - `num_pass`=0 → behaves as 1 pass.
  - `start` asserted during ACC and DRAIN → ignored; the job completes unchanged.
  - `in_valid`=1 during IDLE and DRAIN → `mem` unchanged.

Source files
------------

// File: rtl/sfp_accum.sv
// sfp_accum: output-side psum accumulator placed after the MAC column.
// Sums num_pass passes of depth psums with saturation, then drains them.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 begin a job (IDLE only)
//   num_pass, relu_en     job config, sampled at accepted start
//   in_valid/in_psum      psum stream from MAC; in_ready = ACC state
//   out_valid/out_data    drain stream; out_ready from consumer
//   busy, done            status; done pulses after the last drain beat
module sfp_accum #(
    parameter int psum_bw = 16,
    parameter int depth   = 16,
    parameter int pass_bw = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [pass_bw-1:0] num_pass,
    input  logic               relu_en,
    input  logic               in_valid,
    input  logic [psum_bw-1:0] in_psum,
    output logic               in_ready,
    output logic               out_valid,
    output logic [psum_bw-1:0] out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam int AW = $clog2(depth);
    localparam logic [psum_bw-1:0] MAXV = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] MINV = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_addr;
    logic [pass_bw-1:0] r_pass;
    logic [pass_bw-1:0] r_npass;
    logic               r_relu;
    logic               r_done;
    logic [psum_bw-1:0] r_mem [depth];

    logic               w_beat;
    logic               w_hs;
    logic               w_wrap;
    logic               w_last_pass;
    logic [psum_bw-1:0] w_rd;
    logic [psum_bw:0]   w_sum;
    logic [psum_bw-1:0] w_sat;
    logic [psum_bw-1:0] w_wr;

    assign w_beat      = (r_state == S_ACC) && in_valid;
    assign w_hs        = (r_state == S_DRAIN) && out_ready;
    assign w_wrap      = (r_addr == AW'(depth - 1));
    assign w_last_pass = (r_pass == r_npass - pass_bw'(1));
    assign w_rd        = r_mem[r_addr];

    // One guard bit: overflow shows as the top two bits disagreeing.
    assign w_sum = {w_rd[psum_bw-1], w_rd} + {in_psum[psum_bw-1], in_psum};
    assign w_sat = (w_sum[psum_bw] != w_sum[psum_bw-1])
                 ? (w_sum[psum_bw] ? MINV : MAXV)
                 : w_sum[psum_bw-1:0];
    // Pass 0 overwrites, so stale bank contents never leak into a job.
    assign w_wr  = (r_pass == '0) ? in_psum : w_sat;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ACC;
            S_ACC:   if (w_beat && w_wrap && w_last_pass) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_hs && w_wrap) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_pass  <= '0;
            r_npass <= pass_bw'(1);
            r_relu  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_done <= w_hs && w_wrap;
            if ((r_state == S_IDLE) && start) begin
                r_addr  <= '0;
                r_pass  <= '0;
                r_npass <= (num_pass == '0) ? pass_bw'(1) : num_pass;
                r_relu  <= relu_en;
            end else if (w_beat) begin
                r_mem[r_addr] <= w_wr;
                r_addr        <= r_addr + AW'(1);
                if (w_wrap) begin
                    r_pass <= r_pass + pass_bw'(1);
                end
            end else if (w_hs) begin
                r_addr <= r_addr + AW'(1);
            end
        end
    end

    assign in_ready  = (r_state == S_ACC);
    assign out_valid = (r_state == S_DRAIN);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign out_data  = !out_valid ? '0
                     : ((r_relu && w_rd[psum_bw-1]) ? '0 : w_rd);

endmodule

// File: tb/tb_sfp_accum.sv
// tb_sfp_accum: directed bench for sfp_accum with a job-level model
// checked every cycle, plus literal expectations per job.
module tb_sfp_accum;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  num_pass = '0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_psum = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    sfp_accum dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_pass  (num_pass),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_psum   (in_psum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    // Job-level model: phase, beat count, bank contents, drain list.
    int m_phase = 0;
    int m_np = 1;
    int m_relu = 0;
    int m_idx = 0;
    int m_didx = 0;
    int m_done = 0;
    int mem_m [DEPTH];
    int m_exp [DEPTH];
    int got_q [$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            m_phase = 0;
            m_done = 0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        end else begin
            int nd;
            nd = 0;
            chk("in_ready", int'(in_ready), int'(m_phase == 1));
            chk("out_valid", int'(out_valid), int'(m_phase == 2));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("done", int'(done), m_done);
            if (done) done_cnt++;
            if (m_phase == 2)
                chk("out_data", int'($signed(out_data)), m_exp[m_didx]);
            case (m_phase)
                0: if (start) begin
                    m_np = (num_pass == 0) ? 1 : int'(num_pass);
                    m_relu = int'(relu_en);
                    m_idx = 0;
                    m_phase = 1;
                end
                1: if (in_valid) begin
                    int a;
                    int v;
                    a = m_idx % DEPTH;
                    v = int'($signed(in_psum));
                    mem_m[a] = (m_idx < DEPTH) ? v : clamp(mem_m[a] + v);
                    m_idx++;
                    if (m_idx == m_np * DEPTH) begin
                        for (int i = 0; i < DEPTH; i++)
                            m_exp[i] = (m_relu != 0 && mem_m[i] < 0) ? 0 : mem_m[i];
                        m_didx = 0;
                        m_phase = 2;
                    end
                end
                2: if (out_ready) begin
                    got_q.push_back(int'($signed(out_data)));
                    m_didx++;
                    if (m_didx == DEPTH) begin
                        m_phase = 0;
                        nd = 1;
                    end
                end
                default: m_phase = 0;
            endcase
            m_done = nd;
        end
    end

    function automatic int psum_of(int pat, int p, int a);
        case (pat)
            0: return a;
            1: return a + 1;
            2: begin
                if (a == 0) return (p == 0) ? 30000 : 5000;
                if (a == 1) return (p == 0) ? -30000 : -5000;
                return a;
            end
            3: return (a % 2 == 0) ? -7 : 7;
            default: return 0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int np, int relu);
        start = 1'b1;
        num_pass = 4'(np);
        relu_en = relu[0];
        cyc();
        start = 1'b0;
    endtask

    task automatic feed(int np, int pat, bit gaps, bit stray);
        for (int p = 0; p < np; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        in_psum = 16'($urandom);
                        start = stray;
                        cyc();
                    end
                end
                in_valid = 1'b1;
                in_psum = 16'(psum_of(pat, p, a));
                start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc();
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    // mode 0: always ready; 1: random; 2: random with a 4-cycle stall at entry 5
    task automatic drain(int mode, bit stray);
        int n = 0;
        int stall = 0;
        int guard = 0;
        bit hs;
        while (n < DEPTH && guard < 2000) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 2 && n == 5 && stall < 4) begin
                out_ready = 1'b0;
                stall++;
            end else out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_psum = 16'($urandom);
            start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            hs = out_valid && out_ready;
            cyc();
            if (hs) n++;
            guard++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        if (guard >= 2000) chk("drain_timeout", n, DEPTH);
    endtask

    task automatic run_job(int np, int relu, int pat, bit gaps,
                           int dmode, bit stray);
        int d0;
        int npe;
        got_q.delete();
        d0 = done_cnt;
        npe = (np == 0) ? 1 : np;
        pulse_start(np, relu);
        feed(npe, pat, gaps, stray);
        drain(dmode, stray);
        cyc();
        cyc();
        chk("done_once", done_cnt - d0, 1);
        chk("drain_len", got_q.size(), DEPTH);
    endtask

    initial begin
        repeat (3) cyc();
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_psum = 16'd55;
        cyc();
        cyc();
        in_valid = 1'b0;

        // Reset in the middle of accumulation
        pulse_start(2, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_psum = 16'd100;
            cyc();
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_in_ready", int'(in_ready), 0);
        chk("async_out_valid", int'(out_valid), 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        run_job(1, 0, 0, 1'b0, 0, 1'b0);
        if (got_q.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) chk("lit_ramp", got_q[i], i);

        run_job(3, 0, 1, 1'b1, 1, 1'b0);
        if (got_q.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) chk("lit_3pass", got_q[i], 3 * (i + 1));

        run_job(2, 0, 2, 1'b0, 0, 1'b0);
        if (got_q.size() == DEPTH) begin
            chk("lit_sat_pos", got_q[0], 32767);
            chk("lit_sat_neg", got_q[1], -32768);
            chk("lit_sat_e2", got_q[2], 4);
        end

        run_job(1, 1, 3, 1'b0, 1, 1'b0);
        if (got_q.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++)
                chk("lit_relu", got_q[i], (i % 2 == 0) ? 0 : 7);

        run_job(1, 0, 3, 1'b0, 0, 1'b0);
        if (got_q.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++)
                chk("lit_norelu", got_q[i], (i % 2 == 0) ? -7 : 7);

        run_job(1, 0, 1, 1'b1, 2, 1'b0);
        if (got_q.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) chk("lit_bp", got_q[i], i + 1);

        run_job(0, 0, 1, 1'b1, 1, 1'b1);
        if (got_q.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) chk("lit_np0", got_q[i], i + 1);

        chk("done_total", done_cnt, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
